// File: rtl/ita_input_writer_pkg.sv
// ita_input_writer_pkg: shared ITA sizes and types used by the input writer
package ita_input_writer_pkg;
    localparam int unsigned E = 64;
    localparam int unsigned S = 64;
    localparam int unsigned WI = 8;
    localparam int unsigned InWriterBeatBytes = 8;
    typedef logic [$clog2(S+1)-1:0] seq_length_t;
    typedef struct packed {
        logic [$clog2(S)-1:0] addr;
        logic [E-1:0][WI-1:0] data;
    } write_port_t;
    typedef logic [InWriterBeatBytes-1:0][WI-1:0] inp_beat_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} in_writer_state_e;
endpackage

// File: rtl/ita_input_writer.sv
// ita_input_writer: assembles input beats into E-byte rows and writes them to the input buffer
module ita_input_writer
    import ita_input_writer_pkg::*;
#(
    parameter int unsigned BeatBytes = InWriterBeatBytes
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  seq_length_t             seq_length_i,
    input  logic                    inp_valid_i,
    output logic                    inp_ready_o,
    input  logic [BeatBytes*WI-1:0] inp_data_i,
    output logic                    write_valid_o,
    input  logic                    write_ready_i,
    output write_port_t             write_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int unsigned Beats = E / BeatBytes;
    localparam int unsigned CntW = Beats > 1 ? $clog2(Beats) : 1;
    localparam int unsigned AddrW = $clog2(S);

    if (E % BeatBytes != 0) begin : g_beat_check
        $error("E must be a multiple of BeatBytes");
    end

    in_writer_state_e state_q, state_d;
    seq_length_t seq_q, rows_in_q, rows_out_q, seq_sat;
    logic [CntW-1:0] beat_q;
    logic [Beats-1:0][BeatBytes*WI-1:0] asm_q, row;
    logic last, acc, wr_hs;

    assign seq_sat = seq_length_i > seq_length_t'(S) ? seq_length_t'(S) : seq_length_i;
    assign last = beat_q == CntW'(Beats - 1);
    // The last beat of a row may only enter when the output register is free or draining this cycle
    assign inp_ready_o = state_q == RUN && rows_in_q < seq_q && (!last || !write_valid_o || write_ready_i);
    assign acc = inp_valid_i && inp_ready_o;
    assign wr_hs = write_valid_o && write_ready_i;

    // Completed row: assembled lanes plus the beat arriving now in the top lane
    always_comb begin
        row = asm_q;
        row[Beats-1] = inp_data_i;
    end

    // Next state and status outputs
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start_i) state_d = seq_sat == '0 ? DONE : RUN;
        else if (state_q == RUN && wr_hs && rows_out_q == seq_q - seq_length_t'(1)) state_d = DONE;
        else if (state_q == DONE) state_d = IDLE;
        busy_o = state_q != IDLE;
        done_o = state_q == DONE;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Counters, assembly buffer and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_q <= '0;
            rows_in_q <= '0;
            rows_out_q <= '0;
            beat_q <= '0;
            asm_q <= '0;
            write_o <= '0;
            write_valid_o <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                seq_q <= seq_sat;
                rows_in_q <= '0;
                rows_out_q <= '0;
                beat_q <= '0;
            end
            if (acc) beat_q <= last ? '0 : beat_q + 1'b1;
            if (acc && !last) asm_q[beat_q] <= inp_data_i;
            if (acc && last) begin
                write_o.addr <= rows_in_q[AddrW-1:0];
                write_o.data <= row;
                rows_in_q <= rows_in_q + 1'b1;
            end
            if (wr_hs) rows_out_q <= rows_out_q + 1'b1;
            if (acc && last) write_valid_o <= 1'b1;
            else if (wr_hs) write_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ita_input_writer.sv
// tb_ita_input_writer: directed self-checking bench for ita_input_writer
module tb_ita_input_writer;
    import ita_input_writer_pkg::*;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, inp_valid = 1'b0, write_ready = 1'b1;
    logic inp_ready, write_valid, busy, done;
    seq_length_t seq_len = '0;
    logic [63:0] inp_data = '0;
    write_port_t wr;
    int passed = 0, total = 0, beats_acc = 0;
    write_port_t got_q[$];
    write_port_t held;
    logic held_v = 1'b0;

    always #5 clk = ~clk;

    ita_input_writer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .seq_length_i(seq_len),
        .inp_valid_i(inp_valid), .inp_ready_o(inp_ready), .inp_data_i(inp_data),
        .write_valid_o(write_valid), .write_ready_i(write_ready), .write_o(wr),
        .busy_o(busy), .done_o(done)
    );

    task automatic check(input string tag, input logic [519:0] got, input logic [519:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic write_port_t exp_row(input int addr, input int base);
        exp_row.addr = 6'(addr);
        for (int i = 0; i < 64; i++) exp_row.data[i] = 8'(base + i);
    endfunction

    function automatic logic [63:0] beat(input int base);
        for (int b = 0; b < 8; b++) beat[b*8 +: 8] = 8'(base + b);
    endfunction

    // Observe handshakes and check that a stalled row stays put
    always @(posedge clk) begin
        if (inp_valid && inp_ready) beats_acc++;
        if (write_valid && write_ready) got_q.push_back(wr);
        if (held_v && write_valid) check("hold_stable", wr, held);
        held_v = write_valid && !write_ready;
        held = wr;
    end

    // Called at a negedge; returns at the negedge after acceptance or after max cycles
    task automatic push_beat(input logic [63:0] d, input int max, output bit ok);
        int n;
        n = 0;
        ok = 0;
        inp_data = d;
        inp_valid = 1'b1;
        while (n < max) begin
            #1;
            if (inp_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
        end
        inp_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        seq_len = seq_length_t'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit ok, all_ok, any_ok;
        int b0, n;
        #1;
        check("rst_valid", write_valid, 0);
        check("rst_ready", inp_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write", wr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two rows back to back, sink always ready
        do_start(2);
        check("t1_busy", busy, 1);
        all_ok = 1;
        for (int i = 0; i < 16; i++) begin
            push_beat(beat(i * 8), 4, ok);
            all_ok &= ok;
            if (i == 7) begin
                check("t1_row0_valid", write_valid, 1);
                check("t1_row0", wr, exp_row(0, 0));
            end
        end
        check("t1_all_acc", all_ok, 1);
        check("t1_row1_valid", write_valid, 1);
        check("t1_row1", wr, exp_row(1, 64));
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_valid_clr", write_valid, 0);
        check("t1_rows", got_q.size(), 2);
        check("t1_q0", got_q[0], exp_row(0, 0));
        check("t1_q1", got_q[1], exp_row(1, 64));
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);

        // Backpressure: sink stalls for 12 cycles after row 0 appears
        got_q.delete();
        write_ready = 1'b0;
        b0 = beats_acc;
        do_start(2);
        all_ok = 1;
        fork
            for (int i = 0; i < 16; i++) begin
                push_beat(beat(i * 8), 20, ok);
                all_ok &= ok;
            end
            begin
                n = 0;
                while (!write_valid && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                check("t2_row0_seen", write_valid, 1);
                check("t2_row0", wr, exp_row(0, 0));
                repeat (12) @(negedge clk);
                check("t2_stalled_beats", beats_acc - b0, 15);
                check("t2_ready_low", inp_ready, 0);
                check("t2_row0_held", wr, exp_row(0, 0));
                write_ready = 1'b1;
            end
        join
        check("t2_all_acc", all_ok, 1);
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t2_done", done, 1);
        check("t2_rows", got_q.size(), 2);
        check("t2_q0", got_q[0], exp_row(0, 0));
        check("t2_q1", got_q[1], exp_row(1, 64));
        @(negedge clk);

        // Zero-length transfer
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        seq_len = '0;
        @(negedge clk);
        start = 1'b0;
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        check("t3_valid", write_valid, 0);
        @(negedge clk);
        check("t3_done_pulse", done, 0);
        check("t3_idle", busy, 0);
        check("t3_rows", got_q.size(), 0);

        // One row, a start pulse mid-run, and surplus beats
        got_q.delete();
        b0 = beats_acc;
        do_start(1);
        all_ok = 1;
        for (int i = 0; i < 3; i++) begin
            push_beat(beat(50 + i * 8), 4, ok);
            all_ok &= ok;
        end
        start = 1'b1;
        seq_len = seq_length_t'(5);
        @(negedge clk);
        start = 1'b0;
        check("t5_busy", busy, 1);
        for (int i = 3; i < 8; i++) begin
            push_beat(beat(50 + i * 8), 4, ok);
            all_ok &= ok;
        end
        check("t4_all_acc", all_ok, 1);
        check("t4_row_valid", write_valid, 1);
        check("t4_row", wr, exp_row(0, 50));
        any_ok = 0;
        for (int i = 0; i < 3; i++) begin
            push_beat(beat(200 + i * 8), 3, ok);
            any_ok |= ok;
        end
        check("t4_extra_rejected", any_ok, 0);
        check("t4_beats", beats_acc - b0, 8);
        check("t5_rows", got_q.size(), 1);
        check("t4_q0", got_q[0], exp_row(0, 50));
        check("t4_idle", busy, 0);

        // Reset in the middle of a row, then a clean restart
        got_q.delete();
        do_start(2);
        for (int i = 0; i < 5; i++) push_beat(beat(i * 8), 4, ok);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", inp_ready, 0);
        check("t6_rst_valid", write_valid, 0);
        check("t6_rst_write", wr, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_no_rows", got_q.size(), 0);
        do_start(1);
        all_ok = 1;
        for (int i = 0; i < 8; i++) begin
            push_beat(beat(200 + i * 8), 4, ok);
            all_ok &= ok;
        end
        check("t6_all_acc", all_ok, 1);
        check("t6_row", wr, exp_row(0, 200));
        @(negedge clk);
        check("t6_rows", got_q.size(), 1);
        check("t6_q0", got_q[0], exp_row(0, 200));
        check("t6_done", done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
